// File: rtl/rob_multiport.sv
// rob_multiport: parametrised reorder buffer for the out-of-order core.
//
// Instructions enter in order from decode (up to ALLOC_W per cycle), are
// completed out of order by up to WB_PORTS writeback ports, and retire in
// order (up to COMMIT_W per cycle) to the register file. A mispredicting
// entry retires as the last slot of its commit group and raises flush_out
// with its redirect PC; the whole buffer is then emptied.
//
// Handshake: an allocation group is accepted at the rising edge of clk_in
// when alloc_ready && |alloc_valid; slot i lands at alloc_idx[i]. When
// alloc_ready is low nothing is written. Writebacks and commits have no
// back-pressure: a wb_valid strobe always applies (unless the target entry
// is not allocated or a flush is retiring), and commit_valid slots always
// retire at the edge.
//
// Ports:
//   clk_in, rst_in               clock, synchronous active-high reset
//   alloc_valid/dest/reg_we/nzcv_we, alloc_ready, alloc_idx  allocation
//   wb_valid/idx/value/nzcv/mispredict/redirect_pc           writeback
//   commit_valid/idx/dest/reg_we/value/nzcv_we/nzcv          commit
//   flush_out, flush_pc          mispredict redirect
//   count_out, empty_out, full_out  occupancy
//   halt_out                     only with ROB_HALT_EN defined
//
// Build option: define ROB_HALT_EN to add halt_out. A committing mispredict
// whose redirect PC is 0 (return from main) then halts the buffer until reset.

module rob_multiport #(
   parameter int  DEPTH    = 16,
   parameter int  ALLOC_W  = 2,
   parameter int  WB_PORTS = 2,
   parameter int  COMMIT_W = 2,
   parameter int  REG_W    = 5,
   parameter int  DATA_W   = 64,
   parameter int  ADDR_W   = 64,
   localparam int IDX_W    = $clog2(DEPTH)
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [ALLOC_W-1:0]           alloc_valid,
   input  logic [ALLOC_W*REG_W-1:0]     alloc_dest,
   input  logic [ALLOC_W-1:0]           alloc_reg_we,
   input  logic [ALLOC_W-1:0]           alloc_nzcv_we,
   output logic                         alloc_ready,
   output logic [ALLOC_W*IDX_W-1:0]     alloc_idx,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
   input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
   input  logic [WB_PORTS*4-1:0]        wb_nzcv,
   input  logic [WB_PORTS-1:0]          wb_mispredict,
   input  logic [WB_PORTS*ADDR_W-1:0]   wb_redirect_pc,
   output logic [COMMIT_W-1:0]          commit_valid,
   output logic [COMMIT_W*IDX_W-1:0]    commit_idx,
   output logic [COMMIT_W*REG_W-1:0]    commit_dest,
   output logic [COMMIT_W-1:0]          commit_reg_we,
   output logic [COMMIT_W*DATA_W-1:0]   commit_value,
   output logic [COMMIT_W-1:0]          commit_nzcv_we,
   output logic [COMMIT_W*4-1:0]        commit_nzcv,
   output logic                         flush_out,
   output logic [ADDR_W-1:0]            flush_pc,
   output logic [IDX_W:0]               count_out,
   output logic                         empty_out,
`ifdef ROB_HALT_EN
   output logic                         halt_out,
`endif
   output logic                         full_out
);

   localparam int                CNT_W   = IDX_W + 1;
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   logic [IDX_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   logic [DEPTH-1:0]  valid_q, done_q, misp_q, reg_we_q, nzcv_we_q;
   logic [REG_W-1:0]  dest_q  [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [3:0]        nzcv_q  [DEPTH];
   logic [ADDR_W-1:0] pc_q    [DEPTH];

   logic [IDX_W-1:0]  alloc_slot  [ALLOC_W];
   logic [IDX_W-1:0]  commit_slot [COMMIT_W];
   logic [IDX_W-1:0]  wb_slot     [WB_PORTS];
   logic [CNT_W-1:0]  alloc_n, alloc_cnt, commit_n, free_cnt;
   logic              alloc_fire, halted, go;

   for (genvar i = 0; i < ALLOC_W; i++) begin : g_alloc
      assign alloc_slot[i]                = tail_q + IDX_W'(i);
      assign alloc_idx[i*IDX_W +: IDX_W]  = alloc_slot[i];
   end
   for (genvar j = 0; j < COMMIT_W; j++) begin : g_commit
      assign commit_slot[j] = head_q + IDX_W'(j);
   end
   for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
      assign wb_slot[p] = wb_idx[p*IDX_W +: IDX_W];
   end

`ifdef ROB_HALT_EN
   logic halt_q;
   assign halted   = halt_q;
   assign halt_out = halt_q;

   always_ff @(posedge clk_in) begin
      if (rst_in)
         halt_q <= 1'b0;
      else if (flush_out && flush_pc == '0)
         halt_q <= 1'b1;
   end
`else
   assign halted = 1'b0;
`endif

   // Commit group: walk forward from head, stop at the first entry that is
   // not ready, and close the group right after a mispredict.
   always_comb begin
      commit_valid   = '0;
      commit_idx     = '0;
      commit_dest    = '0;
      commit_reg_we  = '0;
      commit_value   = '0;
      commit_nzcv_we = '0;
      commit_nzcv    = '0;
      flush_out      = 1'b0;
      flush_pc       = '0;
      commit_n       = '0;
      go             = !halted;
      for (int j = 0; j < COMMIT_W; j++) begin
         if (go && valid_q[commit_slot[j]] && done_q[commit_slot[j]]) begin
            commit_valid[j]                   = 1'b1;
            commit_idx[j*IDX_W +: IDX_W]      = commit_slot[j];
            commit_dest[j*REG_W +: REG_W]     = dest_q[commit_slot[j]];
            commit_reg_we[j]                  = reg_we_q[commit_slot[j]];
            commit_value[j*DATA_W +: DATA_W]  = value_q[commit_slot[j]];
            commit_nzcv_we[j]                 = nzcv_we_q[commit_slot[j]];
            commit_nzcv[j*4 +: 4]             = nzcv_q[commit_slot[j]];
            commit_n                          = commit_n + CNT_ONE;
            if (misp_q[commit_slot[j]]) begin
               flush_out = 1'b1;
               flush_pc  = pc_q[commit_slot[j]];
               go        = 1'b0;
            end
         end else begin
            go = 1'b0;
         end
      end
   end

   always_comb begin
      alloc_n = '0;
      for (int i = 0; i < ALLOC_W; i++)
         if (alloc_valid[i]) alloc_n = alloc_n + CNT_ONE;
   end

   // Free space is judged on the pre-commit count: retiring entries do not
   // make room for an allocation in the same cycle.
   assign free_cnt    = CNT_W'(DEPTH) - count_q;
   assign alloc_ready = (free_cnt >= CNT_W'(ALLOC_W)) && !flush_out && !halted;
   assign alloc_fire  = alloc_ready && (|alloc_valid);
   assign alloc_cnt   = alloc_fire ? alloc_n : '0;

   assign count_out = count_q;
   assign empty_out = (count_q == '0);
   assign full_out  = (count_q == CNT_W'(DEPTH));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         done_q  <= '0;
         misp_q  <= '0;
      end else if (flush_out) begin
         // Everything younger than the mispredict is squashed; restart at
         // the slot right after it.
         head_q  <= head_q + commit_n[IDX_W-1:0];
         tail_q  <= head_q + commit_n[IDX_W-1:0];
         count_q <= '0;
         valid_q <= '0;
         done_q  <= '0;
         misp_q  <= '0;
      end else begin
         // Ascending port order: the highest-numbered port wins a collision.
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && valid_q[wb_slot[p]]) begin
               done_q[wb_slot[p]]  <= 1'b1;
               misp_q[wb_slot[p]]  <= wb_mispredict[p];
               value_q[wb_slot[p]] <= wb_value[p*DATA_W +: DATA_W];
               nzcv_q[wb_slot[p]]  <= wb_nzcv[p*4 +: 4];
               pc_q[wb_slot[p]]    <= wb_redirect_pc[p*ADDR_W +: ADDR_W];
            end
         end
         for (int j = 0; j < COMMIT_W; j++) begin
            if (commit_valid[j]) begin
               valid_q[commit_slot[j]] <= 1'b0;
               done_q[commit_slot[j]]  <= 1'b0;
            end
         end
         if (alloc_fire) begin
            for (int i = 0; i < ALLOC_W; i++) begin
               if (alloc_valid[i]) begin
                  valid_q[alloc_slot[i]]   <= 1'b1;
                  done_q[alloc_slot[i]]    <= 1'b0;
                  misp_q[alloc_slot[i]]    <= 1'b0;
                  reg_we_q[alloc_slot[i]]  <= alloc_reg_we[i];
                  nzcv_we_q[alloc_slot[i]] <= alloc_nzcv_we[i];
                  dest_q[alloc_slot[i]]    <= alloc_dest[i*REG_W +: REG_W];
               end
            end
         end
         head_q  <= head_q + commit_n[IDX_W-1:0];
         tail_q  <= tail_q + alloc_cnt[IDX_W-1:0];
         count_q <= count_q + alloc_cnt - commit_n;
      end
   end

endmodule

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: self-checking bench for rob_multiport (DEPTH=8, ALLOC_W=2,
// WB_PORTS=2, COMMIT_W=2). A queue-based reference model predicts, per cycle,
// the status outputs and the commit group; a negedge monitor compares them.

module tb_rob_multiport;

   localparam int DEPTH    = 8;
   localparam int ALLOC_W  = 2;
   localparam int WB_PORTS = 2;
   localparam int COMMIT_W = 2;
   localparam int REG_W    = 5;
   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 64;
   localparam int IDX_W    = $clog2(DEPTH);
   localparam int CW       = IDX_W + REG_W + 2 + 4 + DATA_W;

   logic                        clk_in = 1'b0;
   logic                        rst_in;
   logic [ALLOC_W-1:0]          alloc_valid;
   logic [ALLOC_W*REG_W-1:0]    alloc_dest;
   logic [ALLOC_W-1:0]          alloc_reg_we;
   logic [ALLOC_W-1:0]          alloc_nzcv_we;
   logic                        alloc_ready;
   logic [ALLOC_W*IDX_W-1:0]    alloc_idx;
   logic [WB_PORTS-1:0]         wb_valid;
   logic [WB_PORTS*IDX_W-1:0]   wb_idx;
   logic [WB_PORTS*DATA_W-1:0]  wb_value;
   logic [WB_PORTS*4-1:0]       wb_nzcv;
   logic [WB_PORTS-1:0]         wb_mispredict;
   logic [WB_PORTS*ADDR_W-1:0]  wb_redirect_pc;
   logic [COMMIT_W-1:0]         commit_valid;
   logic [COMMIT_W*IDX_W-1:0]   commit_idx;
   logic [COMMIT_W*REG_W-1:0]   commit_dest;
   logic [COMMIT_W-1:0]         commit_reg_we;
   logic [COMMIT_W*DATA_W-1:0]  commit_value;
   logic [COMMIT_W-1:0]         commit_nzcv_we;
   logic [COMMIT_W*4-1:0]       commit_nzcv;
   logic                        flush_out;
   logic [ADDR_W-1:0]           flush_pc;
   logic [IDX_W:0]              count_out;
   logic                        empty_out;
   logic                        full_out;
`ifdef ROB_HALT_EN
   logic                        halt_out;
`endif

   rob_multiport #(
      .DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W),
      .REG_W(REG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_reg_we(alloc_reg_we),
      .alloc_nzcv_we(alloc_nzcv_we), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value), .wb_nzcv(wb_nzcv),
      .wb_mispredict(wb_mispredict), .wb_redirect_pc(wb_redirect_pc),
      .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_dest(commit_dest),
      .commit_reg_we(commit_reg_we), .commit_value(commit_value),
      .commit_nzcv_we(commit_nzcv_we), .commit_nzcv(commit_nzcv),
      .flush_out(flush_out), .flush_pc(flush_pc), .count_out(count_out),
      .empty_out(empty_out),
`ifdef ROB_HALT_EN
      .halt_out(halt_out),
`endif
      .full_out(full_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_in = ~clk_in;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [REG_W-1:0]  dest;
      logic              reg_we;
      logic              nzcv_we;
      logic              done;
      logic              misp;
      logic [DATA_W-1:0] value;
      logic [3:0]        nzcv;
      logic [ADDR_W-1:0] pc;
   } ent_t;

   typedef struct packed {
      logic                       ready;
      logic [IDX_W:0]             count;
      logic                       empty;
      logic                       full;
      logic [ALLOC_W*IDX_W-1:0]   aidx;
      logic [COMMIT_W-1:0]        cvalid;
      logic [COMMIT_W-1:0]        creg_we;
      logic [COMMIT_W-1:0]        cnzcv_we;
      logic                       flush;
      logic [ADDR_W-1:0]          fpc;
      logic                       halt;
   } status_t;

   ent_t           rob_q[$];      // in-flight entries, oldest first
   logic [CW-1:0]  exp_q[$];      // expected commit slots, in order
   status_t        status_q[$];   // expected per-cycle status
   int             m_head, m_tail;
   bit             m_halt;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [ALLOC_W*IDX_W-1:0] aidx_of(input int tail);
      logic [ALLOC_W*IDX_W-1:0] v;
      v = '0;
      for (int i = 0; i < ALLOC_W; i++) v[i*IDX_W +: IDX_W] = IDX_W'((tail + i) % DEPTH);
      return v;
   endfunction

   task automatic model_reset();
      rob_q.delete();
      m_head = 0;
      m_tail = 0;
      m_halt = 0;
   endtask

   // Predict this cycle's outputs from the current inputs, then advance the
   // model to the post-edge state.
   task automatic model_step();
      status_t st;
      ent_t    e;
      int      n, k;
      bit      fl;
      logic [ADDR_W-1:0] fpc;
      st  = '0;
      n   = 0;
      fl  = 0;
      fpc = '0;
      if (!m_halt) begin
         for (int s = 0; s < COMMIT_W && s < rob_q.size(); s++) begin
            e = rob_q[s];
            if (!e.done) break;
            n++;
            st.cvalid[s]   = 1'b1;
            st.creg_we[s]  = e.reg_we;
            st.cnzcv_we[s] = e.nzcv_we;
            exp_q.push_back({e.idx, e.dest, e.reg_we, e.nzcv_we, e.nzcv, e.value});
            if (e.misp) begin
               fl  = 1;
               fpc = e.pc;
               break;
            end
         end
      end
      st.ready = ((DEPTH - rob_q.size()) >= ALLOC_W) && !fl && !m_halt;
      st.count = (IDX_W+1)'(rob_q.size());
      st.empty = (rob_q.size() == 0);
      st.full  = (rob_q.size() == DEPTH);
      st.aidx  = aidx_of(m_tail);
      st.flush = fl;
      st.fpc   = fpc;
      st.halt  = m_halt;
      status_q.push_back(st);

      if (!fl) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p]) begin
               k = (int'(wb_idx[p*IDX_W +: IDX_W]) - m_head + DEPTH) % DEPTH;
               if (k < rob_q.size()) begin
                  e       = rob_q[k];
                  e.done  = 1'b1;
                  e.misp  = wb_mispredict[p];
                  e.value = wb_value[p*DATA_W +: DATA_W];
                  e.nzcv  = wb_nzcv[p*4 +: 4];
                  e.pc    = wb_redirect_pc[p*ADDR_W +: ADDR_W];
                  rob_q[k] = e;
               end
            end
         end
      end
      repeat (n) void'(rob_q.pop_front());
      m_head = (m_head + n) % DEPTH;
      if (fl) begin
         rob_q.delete();
         m_tail = m_head;
`ifdef ROB_HALT_EN
         if (fpc == '0) m_halt = 1;
`endif
      end
      if (st.ready && alloc_valid != '0) begin
         for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_valid[i]) begin
               e         = '0;
               e.idx     = IDX_W'(m_tail);
               e.dest    = alloc_dest[i*REG_W +: REG_W];
               e.reg_we  = alloc_reg_we[i];
               e.nzcv_we = alloc_nzcv_we[i];
               rob_q.push_back(e);
               m_tail = (m_tail + 1) % DEPTH;
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin : monitor
      status_t       st;
      logic [CW-1:0] e, a;
      if (!rst_in && status_q.size() > 0) begin
         st = status_q.pop_front();
         check("alloc_ready", alloc_ready, st.ready);
         check("count_out", count_out, st.count);
         check("empty_out", empty_out, st.empty);
         check("full_out", full_out, st.full);
         check("alloc_idx", alloc_idx, st.aidx);
         check("commit_valid", commit_valid, st.cvalid);
         check("commit_reg_we", commit_reg_we, st.creg_we);
         check("commit_nzcv_we", commit_nzcv_we, st.cnzcv_we);
         check("flush_out", flush_out, st.flush);
         if (st.flush) check("flush_pc", flush_pc, st.fpc);
`ifdef ROB_HALT_EN
         check("halt_out", halt_out, st.halt);
`endif
         for (int j = 0; j < COMMIT_W; j++) begin
            if (st.cvalid[j] && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               a = {commit_idx[j*IDX_W +: IDX_W], commit_dest[j*REG_W +: REG_W],
                    commit_reg_we[j], commit_nzcv_we[j], commit_nzcv[j*4 +: 4],
                    commit_value[j*DATA_W +: DATA_W]};
               check("commit_slot", a, e);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      alloc_valid    = '0;
      alloc_dest     = '0;
      alloc_reg_we   = '0;
      alloc_nzcv_we  = '0;
      wb_valid       = '0;
      wb_idx         = '0;
      wb_value       = '0;
      wb_nzcv        = '0;
      wb_mispredict  = '0;
      wb_redirect_pc = '0;
   endtask

   task automatic alloc_slot(input int i, input logic [REG_W-1:0] d, input logic rwe, input logic nwe);
      alloc_valid[i]                = 1'b1;
      alloc_dest[i*REG_W +: REG_W]  = d;
      alloc_reg_we[i]               = rwe;
      alloc_nzcv_we[i]              = nwe;
   endtask

   task automatic alloc_rand(input int n);
      for (int i = 0; i < n; i++)
         alloc_slot(i, REG_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic wb_port(input int p, input int idx, input logic [DATA_W-1:0] v,
                          input logic misp, input logic [ADDR_W-1:0] pc);
      wb_valid[p]                        = 1'b1;
      wb_idx[p*IDX_W +: IDX_W]           = IDX_W'(idx);
      wb_value[p*DATA_W +: DATA_W]       = v;
      wb_nzcv[p*4 +: 4]                  = 4'($urandom_range(0, 15));
      wb_mispredict[p]                   = misp;
      wb_redirect_pc[p*ADDR_W +: ADDR_W] = pc;
   endtask

   // One clock: predict with the current inputs, let the edge happen, clear.
   task automatic cycle();
      model_step();
      @(posedge clk_in);
      #1;
      clear_inputs();
   endtask

   task automatic do_reset(input bit inflight);
      rst_in = 1'b1;
      if (inflight) begin
         alloc_rand(ALLOC_W);
         wb_port(0, 0, 64'hdead, 1'b0, 64'h0);
         wb_port(1, 2, 64'hbeef, 1'b1, 64'h80);
      end
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      clear_inputs();
      model_reset();
   endtask

   task automatic random_cycle(input bit allow_alloc);
      int idx, k;
      if (allow_alloc) alloc_rand($urandom_range(0, ALLOC_W));
      for (int p = 0; p < WB_PORTS; p++) begin
         if ($urandom_range(0, 9) < 6) begin
            idx = $urandom_range(0, DEPTH - 1);
            if (rob_q.size() > 0 && $urandom_range(0, 7) != 0) begin
               k = $urandom_range(0, rob_q.size() - 1);
               if (!allow_alloc)
                  for (int s = rob_q.size() - 1; s >= 0; s--) if (!rob_q[s].done) k = s;
               idx = int'(rob_q[k].idx);
            end
            wb_port(p, idx, {$urandom, $urandom}, 1'($urandom_range(0, 15) == 0),
                    {$urandom, $urandom} | 64'h1);
         end
      end
      cycle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clear_inputs();
      model_reset();
      rst_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;

      // Reset state
      check("reset_alloc_ready", alloc_ready, 1'b1);
      check("reset_empty", empty_out, 1'b1);
      check("reset_count", count_out, '0);
      check("reset_alloc_idx", alloc_idx, aidx_of(0));
      check("reset_commit_valid", commit_valid, '0);

      // Basic in-order retire
      alloc_slot(0, 5'd3, 1'b1, 1'b1);
      alloc_slot(1, 5'd4, 1'b1, 1'b0);
      cycle();
      wb_port(0, 1, 64'h22, 1'b0, 64'h0);
      cycle();
      check("basic_wait_head", commit_valid, 2'b00);
      wb_port(0, 0, 64'h11, 1'b0, 64'h0);
      cycle();
      check("basic_commit_valid", commit_valid, 2'b11);
      check("basic_value0", commit_value[63:0], 64'h11);
      check("basic_value1", commit_value[127:64], 64'h22);
      cycle();
      check("basic_count", count_out, '0);

      // Full and wrap
      do_reset(0);
      repeat (3) begin alloc_rand(2); cycle(); end
      alloc_rand(1);
      cycle();
      check("count7_ready", alloc_ready, 1'b0);
      check("count7_full", full_out, 1'b0);
      wb_port(0, 0, 64'h1234, 1'b0, 64'h0);
      cycle();
      cycle();
      check("wrap_alloc_idx_a", alloc_idx, aidx_of(7));
      alloc_rand(2);
      cycle();
      check("count8_full", full_out, 1'b1);
      check("count8_ready", alloc_ready, 1'b0);
      wb_port(0, 1, {$urandom, $urandom}, 1'b0, 64'h0);
      wb_port(1, 2, {$urandom, $urandom}, 1'b0, 64'h0);
      cycle();
      cycle();
      check("wrap_alloc_idx_b", alloc_idx, aidx_of(1));
      alloc_rand(2);
      cycle();
      for (int k = 0; k < 4; k++) begin
         wb_port(0, (3 + 2 * k) % DEPTH, {$urandom, $urandom}, 1'b0, 64'h0);
         wb_port(1, (4 + 2 * k) % DEPTH, {$urandom, $urandom}, 1'b0, 64'h0);
         cycle();
      end
      repeat (2) cycle();
      check("wrap_drained", count_out, '0);

      // Mispredict flush
      do_reset(0);
      repeat (2) begin alloc_rand(2); cycle(); end
      wb_port(0, 0, 64'haaaa, 1'b0, 64'h0);
      wb_port(1, 1, 64'hbbbb, 1'b1, 64'h400);
      cycle();
      check("misp_flush", flush_out, 1'b1);
      check("misp_flush_pc", flush_pc, 64'h400);
      check("misp_commit_valid", commit_valid, 2'b11);
      wb_port(0, 2, 64'hcccc, 1'b0, 64'h0);
      cycle();
      check("misp_count", count_out, '0);
      wb_port(0, 2, 64'hdddd, 1'b0, 64'h0);
      cycle();
      check("misp_idx2_gone", commit_valid, 2'b00);

      // Writeback edge cases
      do_reset(0);
      alloc_rand(2);
      cycle();
      wb_port(0, 0, 64'h5555, 1'b0, 64'h0);
      wb_port(1, 0, 64'h6666, 1'b0, 64'h0);
      cycle();
      check("wb_collision_value", commit_value[63:0], 64'h6666);
      wb_port(0, 5, 64'h7777, 1'b1, 64'h0);
      cycle();
      wb_port(0, 1, 64'h8888, 1'b0, 64'h0);
      cycle();
      cycle();

      // Reset mid-operation
      do_reset(0);
      alloc_rand(2); cycle();
      alloc_rand(2); cycle();
      alloc_rand(1);
      wb_port(0, 1, {$urandom, $urandom}, 1'b0, 64'h0);
      cycle();
      do_reset(1);
      check("midrst_empty", empty_out, 1'b1);
      wb_port(0, 0, 64'h9999, 1'b0, 64'h0);
      cycle();
      check("midrst_stale_wb", commit_valid, 2'b00);

`ifdef ROB_HALT_EN
      // Halt on return-from-main
      do_reset(0);
      alloc_rand(2);
      cycle();
      wb_port(0, 0, 64'h1, 1'b1, 64'h0);
      cycle();
      check("halt_flush", flush_out, 1'b1);
      cycle();
      check("halt_set", halt_out, 1'b1);
      wb_port(0, 1, 64'h2, 1'b0, 64'h0);
      alloc_rand(2);
      cycle();
      check("halt_no_commit", commit_valid, 2'b00);
      cycle();
`endif

      // Randomised traffic, then drain
      do_reset(0);
      repeat (800) random_cycle(1'b1);
      repeat (40) random_cycle(1'b0);
      repeat (2) cycle();
      check("end_count", count_out, (IDX_W+1)'(rob_q.size()));
      check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
